// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and
// default address-map constants for the instruction ROM.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEF_RESET_PC   = 32'd0;
  localparam logic [31:0] DEF_PC_STEP    = 32'd2;
  localparam logic [31:0] DEF_IMEM_LIMIT = 32'd64;
  localparam logic [31:0] NOP            = 32'd0;

endpackage

// File: rtl/pc_next_sel.sv
// Redirect selection for the fetch PC: jump beats branch, the target is
// forced to even alignment and an odd raw target is flagged.
module pc_next_sel (
  input  logic        redirect_jump,
  input  logic [31:0] jump_target,
  input  logic        redirect_branch,
  input  logic [31:0] branch_target,
  output logic        redirect,
  output logic [31:0] target,
  output logic        misalign_raw
);

  logic [31:0] raw_target;

  assign raw_target   = redirect_jump ? jump_target : branch_target;
  assign redirect     = redirect_jump | redirect_branch;
  assign target       = {raw_target[31:1], 1'b0};
  assign misalign_raw = redirect & raw_target[0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads the combinational ROM and loads the IF/ID
// register under a valid/ready handshake, with EX redirects and range halt.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] PC_STEP    = DEF_PC_STEP,
  parameter logic [31:0] IMEM_LIMIT = DEF_IMEM_LIMIT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  input  logic [31:0] instruction,
  input  logic        redirect_jump,
  input  logic [31:0] jump_target,
  input  logic        redirect_branch,
  input  logic [31:0] branch_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_next,
  output logic        if_id_valid,
  input  logic        if_id_ready,
  output logic        fetch_fault,
  output logic        misalign,
  output logic [31:0] fetch_count
);

  fetch_state_t state, state_next;

  logic        redirect;
  logic [31:0] target;
  logic        misalign_raw;
  logic        take_redirect;
  logic        in_range;
  logic        advance;
  logic [31:0] pc_inc;

  pc_next_sel u_pc_next_sel (
    .redirect_jump   (redirect_jump),
    .jump_target     (jump_target),
    .redirect_branch (redirect_branch),
    .branch_target   (branch_target),
    .redirect        (redirect),
    .target          (target),
    .misalign_raw    (misalign_raw)
  );

  // Redirects are ignored during the single BOOT cycle.
  assign take_redirect = redirect && (state != ST_BOOT);
  assign in_range      = pc < IMEM_LIMIT;
  assign advance       = (state == ST_RUN) && (!if_id_valid || if_id_ready) && in_range;
  assign pc_inc        = pc + PC_STEP;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    if (take_redirect) begin
      state_next = ST_RUN;
    end else begin
      case (state)
        ST_BOOT: state_next = ST_RUN;
        ST_RUN:  if (!in_range) state_next = ST_HALT;
        ST_HALT: state_next = ST_HALT;
        default: state_next = ST_BOOT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BOOT;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      if_id_instr   <= NOP;
      if_id_pc_next <= 32'd0;
      if_id_valid   <= 1'b0;
      fetch_fault   <= 1'b0;
      misalign      <= 1'b0;
      fetch_count   <= 32'd0;
    end else begin
      misalign <= 1'b0;
      if (take_redirect) begin
        // Squash the wrong-path word even when decode is stalled.
        pc          <= target;
        if_id_valid <= 1'b0;
        fetch_fault <= 1'b0;
        misalign    <= misalign_raw;
      end else if (advance) begin
        if_id_instr   <= instruction;
        if_id_pc_next <= pc_inc;
        if_id_valid   <= 1'b1;
        pc            <= pc_inc;
        fetch_count   <= fetch_count + 32'd1;
      end else begin
        if (if_id_ready) if_id_valid <= 1'b0;
        if ((state == ST_RUN) && !in_range) fetch_fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a ROM model, a vector table of
// per-cycle inputs/expected outputs, and hand-written reset sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        redirect_jump;
  logic [31:0] jump_target;
  logic        redirect_branch;
  logic [31:0] branch_target;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_next;
  logic        if_id_valid;
  logic        if_id_ready;
  logic        fetch_fault;
  logic        misalign;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc              (pc),
    .instruction     (instruction),
    .redirect_jump   (redirect_jump),
    .jump_target     (jump_target),
    .redirect_branch (redirect_branch),
    .branch_target   (branch_target),
    .if_id_instr     (if_id_instr),
    .if_id_pc_next   (if_id_pc_next),
    .if_id_valid     (if_id_valid),
    .if_id_ready     (if_id_ready),
    .fetch_fault     (fetch_fault),
    .misalign        (misalign),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // ROM model: word index pc[5:1], zero at or above the limit.
  assign instruction = (pc < 32'd64) ? w(int'(pc[5:1])) : 32'd0;

  typedef struct {
    logic        ready;
    logic        rj;
    logic [31:0] jt;
    logic        rb;
    logic [31:0] bt;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc_next;
    logic        e_valid;
    logic [31:0] e_count;
    logic        e_fault;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic ready, input logic rj, input logic [31:0] jt,
                     input logic rb, input logic [31:0] bt,
                     input logic [31:0] e_pc, input logic [31:0] e_instr,
                     input logic [31:0] e_pc_next, input logic e_valid,
                     input logic [31:0] e_count, input logic e_fault, input logic e_mis);
    vec_t v;
    v.ready = ready; v.rj = rj; v.jt = jt; v.rb = rb; v.bt = bt;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc_next = e_pc_next;
    v.e_valid = e_valid; v.e_count = e_count; v.e_fault = e_fault; v.e_mis = e_mis;
    vecs.push_back(v);
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_pc_next, input logic e_valid,
                           input logic [31:0] e_count, input logic e_fault, input logic e_mis);
    check({tag, ".pc"},      pc,                   e_pc);
    check({tag, ".instr"},   if_id_instr,          e_instr);
    check({tag, ".pc_next"}, if_id_pc_next,        e_pc_next);
    check({tag, ".valid"},   32'(if_id_valid),     32'(e_valid));
    check({tag, ".count"},   fetch_count,          e_count);
    check({tag, ".fault"},   32'(fetch_fault),     32'(e_fault));
    check({tag, ".mis"},     32'(misalign),        32'(e_mis));
  endtask

  initial begin
    rst_n = 1'b0; if_id_ready = 1'b1;
    redirect_jump = 1'b0; jump_target = 32'd0;
    redirect_branch = 1'b0; branch_target = 32'd0;

    //   rdy rj jt      rb bt      pc      instr   pc_next v  cnt f  m
    add(1, 0, 0,      0, 0,      32'd0,  32'd0,  32'd0,  0, 0,  0, 0); // BOOT
    add(1, 0, 0,      0, 0,      32'd2,  w(0),   32'd2,  1, 1,  0, 0);
    add(1, 0, 0,      0, 0,      32'd4,  w(1),   32'd4,  1, 2,  0, 0);
    add(1, 0, 0,      0, 0,      32'd6,  w(2),   32'd6,  1, 3,  0, 0);
    add(1, 0, 0,      0, 0,      32'd8,  w(3),   32'd8,  1, 4,  0, 0);
    add(1, 0, 0,      0, 0,      32'd10, w(4),   32'd10, 1, 5,  0, 0);
    add(0, 0, 0,      0, 0,      32'd10, w(4),   32'd10, 1, 5,  0, 0); // stall x3
    add(0, 0, 0,      0, 0,      32'd10, w(4),   32'd10, 1, 5,  0, 0);
    add(0, 0, 0,      0, 0,      32'd10, w(4),   32'd10, 1, 5,  0, 0);
    add(1, 0, 0,      0, 0,      32'd12, w(5),   32'd12, 1, 6,  0, 0);
    add(0, 0, 0,      0, 0,      32'd12, w(5),   32'd12, 1, 6,  0, 0);
    add(0, 0, 0,      1, 32'd20, 32'd20, w(5),   32'd12, 0, 6,  0, 0); // branch in stall
    add(1, 0, 0,      0, 0,      32'd22, w(10),  32'd22, 1, 7,  0, 0);
    add(0, 1, 32'd40, 1, 32'd20, 32'd40, w(10),  32'd22, 0, 7,  0, 0); // jump wins
    add(1, 0, 0,      0, 0,      32'd42, w(20),  32'd42, 1, 8,  0, 0);
    add(1, 0, 0,      1, 32'd7,  32'd6,  w(20),  32'd42, 0, 8,  0, 1); // odd target
    add(1, 0, 0,      0, 0,      32'd8,  w(3),   32'd8,  1, 9,  0, 0);
    add(1, 1, 32'd60, 0, 0,      32'd60, w(3),   32'd8,  0, 9,  0, 0);
    add(1, 0, 0,      0, 0,      32'd62, w(30),  32'd62, 1, 10, 0, 0);
    add(1, 0, 0,      0, 0,      32'd64, w(31),  32'd64, 1, 11, 0, 0);
    add(1, 0, 0,      0, 0,      32'd64, w(31),  32'd64, 0, 11, 1, 0); // HALT, drained
    add(1, 0, 0,      0, 0,      32'd64, w(31),  32'd64, 0, 11, 1, 0);
    add(1, 1, 32'd0,  0, 0,      32'd0,  w(31),  32'd64, 0, 11, 0, 0); // resume
    add(1, 0, 0,      0, 0,      32'd2,  w(0),   32'd2,  1, 12, 0, 0);

    #12;
    check_all("reset", 32'd0, 32'd0, 32'd0, 0, 32'd0, 0, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      if_id_ready     = vecs[i].ready;
      redirect_jump   = vecs[i].rj;
      jump_target     = vecs[i].jt;
      redirect_branch = vecs[i].rb;
      branch_target   = vecs[i].bt;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pc_next,
                vecs[i].e_valid, vecs[i].e_count, vecs[i].e_fault, vecs[i].e_mis);
    end

    // Async reset mid-cycle, with a redirect pending across an edge.
    redirect_jump = 1'b0; redirect_branch = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    redirect_branch = 1'b1; branch_target = 32'd30;
    #1;
    check_all("async_rst", 32'd0, 32'd0, 32'd0, 0, 32'd0, 0, 0);
    step();
    check_all("rst_hold", 32'd0, 32'd0, 32'd0, 0, 32'd0, 0, 0);
    #2;
    redirect_branch = 1'b0;
    rst_n = 1'b1;
    // A redirect during BOOT is ignored.
    redirect_jump = 1'b1; jump_target = 32'd40;
    step();
    check_all("boot_again", 32'd0, 32'd0, 32'd0, 0, 32'd0, 0, 0);
    redirect_jump = 1'b0;
    step();
    check_all("refetch0", 32'd2, w(0), 32'd2, 1, 32'd1, 0, 0);
    step();
    check_all("refetch1", 32'd4, w(1), 32'd4, 1, 32'd2, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
